cascade_ctrl: RTL and testbench

- Clocked, parametrised cascade and INTA-sequence controller for the 8259-style PIC.
- Sits between the priority resolver and the data-bus vector driver.
- Operating modes:
  - Master: tracks the 2-pulse (8086) or 3-pulse (8080) INTA sequence, drives the CAS lines with the acknowledged IR number, and decides which device owns each data byte.
  - Slave: decodes the CAS lines and claims the vector bytes.
- Adds INTA synchronisation, sequence tracking, spurious-IR handling and gap timeout.

---
 rtl/pic_pkg.sv | 40 ++++
 rtl/inta_edge_sync.sv | 38 +++
 rtl/cascade_ctrl.sv | 166 ++++++++++++++++
 tb/tb_cascade_ctrl.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pic_pkg.sv
// pic_pkg: shared types and constants for the 8259-style PIC cascade logic.
//   state_t       - cascade/INTA sequencer states
//   VS_*          - byte-select encodings presented to the data-bus driver
//   CALL_OPCODE   - 8080 CALL opcode placed on the bus for the first byte
//   vs_for_pulse  - maps (mode, pulse number) to the byte being transferred
package pic_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    GAP   = 2'd2
  } state_t;

  localparam logic [1:0] VS_NONE = 2'd0;
  localparam logic [1:0] VS_CALL = 2'd1;
  localparam logic [1:0] VS_LOW  = 2'd2;
  localparam logic [1:0] VS_HIGH = 2'd3;

  localparam logic [7:0] CALL_OPCODE = 8'hCD;

  // 8086 only carries a byte on the second pulse; 8080 carries CALL, low
  // address and high address on pulses 1..3.
  function automatic logic [1:0] vs_for_pulse(input logic mode_8086,
                                               input logic [1:0] pulse);
    logic [1:0] vs;
    vs = VS_NONE;
    if (mode_8086) begin
      vs = (pulse == 2'd2) ? VS_LOW : VS_NONE;
    end else begin
      case (pulse)
        2'd1:    vs = VS_CALL;
        2'd2:    vs = VS_LOW;
        2'd3:    vs = VS_HIGH;
        default: vs = VS_NONE;
      endcase
    end
    return vs;
  endfunction

endpackage

// File: rtl/inta_edge_sync.sv
// inta_edge_sync: synchronises the asynchronous inta_n strobe and produces
// single-cycle edge pulses on the synchronised value.
//   clk, rst_n  - clock, asynchronous active-low reset
//   i_inta_n    - raw interrupt-acknowledge strobe
//   o_fall      - synced inta_n went 1 -> 0 (combinational from flops)
//   o_rise      - synced inta_n went 0 -> 1 (combinational from flops)
module inta_edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_inta_n,
  output logic o_fall,
  output logic o_rise
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;
  logic                   w_synced;

  assign w_synced = r_sync[SYNC_STAGES-1];

  // Flops reset to 1 so that releasing reset with inta_n idle (high)
  // never fabricates an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '1;
      r_prev <= 1'b1;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_inta_n};
      r_prev <= w_synced;
    end
  end

  assign o_fall = r_prev & ~w_synced;
  assign o_rise = ~r_prev & w_synced;

endmodule

// File: rtl/cascade_ctrl.sv
// cascade_ctrl: INTA sequence tracker and cascade-bus controller for an
// 8259-style PIC, in master, slave or single mode.
//   sngl/sp_en/mode_8086   - configuration (latched at sequence start)
//   slave_mask, slave_id   - master / slave cascade configuration
//   int_pending, int_id    - priority resolver result
//   inta_n                 - asynchronous acknowledge strobe
//   cas_in / cas_out/cas_oe - cascade bus
//   ack_start, ack_id      - sequence start pulse and acknowledged IR
//   vec_sel, data_oe       - data byte select and data-bus ownership
//   seq_done, seq_abort    - sequence completion / gap-timeout pulses
module cascade_ctrl
  import pic_pkg::*;
#(
  parameter int NUM_IR      = 8,
  parameter int CAS_W       = 3,
  parameter int SYNC_STAGES = 2,
  parameter int GAP_TIMEOUT = 64,
  localparam int ID_W       = (NUM_IR > 1) ? $clog2(NUM_IR) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sngl,
  input  logic              sp_en,
  input  logic              mode_8086,
  input  logic [NUM_IR-1:0] slave_mask,
  input  logic [CAS_W-1:0]  slave_id,
  input  logic              int_pending,
  input  logic [ID_W-1:0]   int_id,
  input  logic              inta_n,
  input  logic [CAS_W-1:0]  cas_in,
  output logic [CAS_W-1:0]  cas_out,
  output logic              cas_oe,
  output logic              ack_start,
  output logic [ID_W-1:0]   ack_id,
  output logic [1:0]        vec_sel,
  output logic              data_oe,
  output logic              seq_done,
  output logic              seq_abort
);

  localparam int GAP_W = $clog2(GAP_TIMEOUT + 1);

  logic w_fall, w_rise;

  inta_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_inta_n (inta_n),
    .o_fall   (w_fall),
    .o_rise   (w_rise)
  );

  state_t           r_state, w_state_next;
  logic [1:0]       r_pulse_cnt, w_pulse_next;
  logic [GAP_W-1:0] r_gap_cnt;
  logic             r_sngl, r_sp_en, r_mode, r_addressed;
  logic [ID_W-1:0]  r_ack_id;
  logic             r_ack_start, r_seq_done, r_seq_abort, r_data_oe;
  logic [1:0]       r_vec_sel;

  logic       w_last, w_gap_expired;
  logic       w_sngl_eff, w_sp_en_eff, w_mode_eff, w_owner;
  logic [1:0] w_vs_next;
  logic       w_oe_next, w_ack_start_next, w_done_next, w_abort_next;
  logic       w_cas_drive;

  assign w_last        = (r_pulse_cnt == (r_mode ? 2'd2 : 2'd3));
  assign w_gap_expired = (r_gap_cnt == GAP_W'(GAP_TIMEOUT - 1));

  // In IDLE the configuration has not been latched yet, so the first-pulse
  // decode must look at the live inputs.
  assign w_sngl_eff  = (r_state == IDLE) ? sngl      : r_sngl;
  assign w_sp_en_eff = (r_state == IDLE) ? sp_en     : r_sp_en;
  assign w_mode_eff  = (r_state == IDLE) ? mode_8086 : r_mode;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  // Next-state logic; a fall while in PULSE cannot happen and is ignored.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      IDLE:  if (w_fall) w_state_next = PULSE;
      PULSE: if (w_rise) w_state_next = w_last ? IDLE : GAP;
      GAP: begin
        if (w_fall)             w_state_next = PULSE;
        else if (w_gap_expired) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Output decode (values registered below)
  always_comb begin
    w_pulse_next = r_pulse_cnt;
    if (r_state == IDLE && w_fall)     w_pulse_next = 2'd1;
    else if (r_state == GAP && w_fall) w_pulse_next = r_pulse_cnt + 2'd1;

    w_vs_next = (w_state_next == PULSE) ? vs_for_pulse(w_mode_eff, w_pulse_next) : VS_NONE;

    // r_ack_id is stale on the first pulse, but there the master owns the
    // byte whether or not a slave hangs off the IR line.
    if (w_sngl_eff)       w_owner = 1'b1;
    else if (w_sp_en_eff) w_owner = slave_mask[r_ack_id] ? (w_vs_next == VS_CALL) : 1'b1;
    else                  w_owner = (w_pulse_next >= 2'd2) && r_addressed;

    w_oe_next        = w_owner && (w_state_next == PULSE) && (w_vs_next != VS_NONE);
    w_ack_start_next = (r_state == IDLE) && w_fall;
    w_done_next      = (r_state == PULSE) && w_rise && w_last && (r_sngl || r_sp_en || r_addressed);
    w_abort_next     = (r_state == GAP) && !w_fall && w_gap_expired;
  end

  // Sequence datapath and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pulse_cnt <= 2'd0;
      r_gap_cnt   <= '0;
      r_sngl      <= 1'b0;
      r_sp_en     <= 1'b0;
      r_mode      <= 1'b0;
      r_addressed <= 1'b0;
      r_ack_id    <= '0;
      r_ack_start <= 1'b0;
      r_seq_done  <= 1'b0;
      r_seq_abort <= 1'b0;
      r_vec_sel   <= VS_NONE;
      r_data_oe   <= 1'b0;
    end else begin
      r_pulse_cnt <= w_pulse_next;
      if (r_state == IDLE && w_fall) begin
        r_sngl      <= sngl;
        r_sp_en     <= sp_en;
        r_mode      <= mode_8086;
        r_addressed <= 1'b0;
        r_ack_id    <= int_pending ? int_id : ID_W'(NUM_IR - 1);
      end
      if (r_state == PULSE && w_rise && r_pulse_cnt == 2'd1 && !r_sngl && !r_sp_en)
        r_addressed <= (cas_in == slave_id);
      if (r_state == PULSE && w_rise)
        r_gap_cnt <= '0;
      else if (r_state == GAP && !w_fall)
        r_gap_cnt <= r_gap_cnt + GAP_W'(1);
      r_ack_start <= w_ack_start_next;
      r_seq_done  <= w_done_next;
      r_seq_abort <= w_abort_next;
      r_vec_sel   <= w_vs_next;
      r_data_oe   <= w_oe_next;
    end
  end

  // Master drives the acknowledged IR onto CAS only when a slave is attached.
  assign w_cas_drive = (r_state != IDLE) && !r_sngl && r_sp_en && slave_mask[r_ack_id];
  assign cas_out     = w_cas_drive ? CAS_W'(r_ack_id) : '0;
  assign cas_oe      = sngl | sp_en;

  assign ack_start = r_ack_start;
  assign ack_id    = r_ack_id;
  assign vec_sel   = r_vec_sel;
  assign data_oe   = r_data_oe;
  assign seq_done  = r_seq_done;
  assign seq_abort = r_seq_abort;

endmodule

// File: tb/tb_cascade_ctrl.sv
// Scoreboard bench for cascade_ctrl: expected events (ack, byte, done,
// abort) are queued as stimulus is driven; a monitor queues observed events.
module tb_cascade_ctrl;
  import pic_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       sngl, sp_en, mode_8086, int_pending, inta_n;
  logic [7:0] slave_mask;
  logic [2:0] slave_id, int_id, cas_in;
  logic [2:0] cas_out;
  logic       cas_oe, ack_start, data_oe, seq_done, seq_abort;
  logic [2:0] ack_id;
  logic [1:0] vec_sel;

  cascade_ctrl #(.NUM_IR(8), .CAS_W(3), .SYNC_STAGES(2), .GAP_TIMEOUT(64)) dut (
    .clk(clk), .rst_n(rst_n), .sngl(sngl), .sp_en(sp_en), .mode_8086(mode_8086),
    .slave_mask(slave_mask), .slave_id(slave_id), .int_pending(int_pending),
    .int_id(int_id), .inta_n(inta_n), .cas_in(cas_in), .cas_out(cas_out),
    .cas_oe(cas_oe), .ack_start(ack_start), .ack_id(ack_id), .vec_sel(vec_sel),
    .data_oe(data_oe), .seq_done(seq_done), .seq_abort(seq_abort)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // kind: 0 = ack (a = ack_id), 1 = byte (a = vec_sel, b = data_oe), 2 = done, 3 = abort
  typedef struct packed {
    logic [1:0] kind;
    logic [7:0] a;
    logic       b;
  } ev_t;

  ev_t        exp_q[$];
  ev_t        obs_q[$];
  logic [1:0] prev_vs = 2'd0;
  bit         oe_seen = 1'b0;

  function automatic ev_t mk(input int k, input int a, input int b);
    ev_t e;
    e.kind = 2'(k);
    e.a    = 8'(a);
    e.b    = 1'(b);
    return e;
  endfunction

  always @(negedge clk) begin
    if (ack_start) obs_q.push_back(mk(0, int'(ack_id), 0));
    if (vec_sel != 2'd0 && prev_vs == 2'd0) obs_q.push_back(mk(1, int'(vec_sel), int'(data_oe)));
    if (seq_done)  obs_q.push_back(mk(2, 0, 0));
    if (seq_abort) obs_q.push_back(mk(3, 0, 0));
    if (data_oe)   oe_seen = 1'b1;
    prev_vs = vec_sel;
  end

  task automatic pulse(input int lo, input int hi, output logic [2:0] cas_lo, output logic [2:0] cas_hi);
    @(posedge clk); #1 inta_n = 1'b0;
    repeat (lo) @(posedge clk);
    #1 cas_lo = cas_out;
    inta_n = 1'b1;
    repeat (hi) @(posedge clk);
    #1 cas_hi = cas_out;
  endtask

  task automatic start_seq();
    repeat (2) @(posedge clk);
    #1;
    exp_q.delete();
    obs_q.delete();
    oe_seen = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; inta_n = 1'b1; sngl = 1'b0; sp_en = 1'b1; mode_8086 = 1'b1;
    slave_mask = 8'h00; slave_id = 3'd0; int_pending = 1'b0; int_id = 3'd0; cas_in = 3'd0;
    #12;
    checks++;
    if ({cas_out, ack_start, ack_id, vec_sel, data_oe, seq_done, seq_abort} !== 12'd0) begin
      errors++;
      $display("FAIL reset_outputs got=%h exp=000", {cas_out, ack_start, ack_id, vec_sel, data_oe, seq_done, seq_abort});
    end
    checks++;
    if (cas_oe !== 1'b1) begin errors++; $display("FAIL reset_cas_oe_master got=%b exp=1", cas_oe); end
    sp_en = 1'b0; #1;
    checks++;
    if (cas_oe !== 1'b0) begin errors++; $display("FAIL reset_cas_oe_slave got=%b exp=0", cas_oe); end
    sngl = 1'b1; #1;
    checks++;
    if (cas_oe !== 1'b1) begin errors++; $display("FAIL reset_cas_oe_single got=%b exp=1", cas_oe); end
    @(posedge clk); #1 rst_n = 1'b1;
    $display("reset: outputs and cas_oe checked");
  endtask

  task automatic test_master_8086();
    logic [2:0] c1l, c1h, c2l, c2h;
    start_seq();
    sngl = 1'b0; sp_en = 1'b1; mode_8086 = 1'b1; slave_mask = 8'h04; int_pending = 1'b1; int_id = 3'd2;
    exp_q.push_back(mk(0, 2, 0)); exp_q.push_back(mk(1, 2, 0)); exp_q.push_back(mk(2, 0, 0));
    pulse(6, 8, c1l, c1h);
    pulse(6, 8, c2l, c2h);
    repeat (4) @(posedge clk); #1;
    checks++; if (c1l !== 3'd2) begin errors++; $display("FAIL m86_cas_p1 got=%0d exp=2", c1l); end
    checks++; if (c1h !== 3'd2) begin errors++; $display("FAIL m86_cas_gap got=%0d exp=2", c1h); end
    checks++; if (c2l !== 3'd2) begin errors++; $display("FAIL m86_cas_p2 got=%0d exp=2", c2l); end
    checks++; if (c2h !== 3'd0) begin errors++; $display("FAIL m86_cas_after got=%0d exp=0", c2h); end
    checks++; if (oe_seen !== 1'b0) begin errors++; $display("FAIL m86_data_oe got=%b exp=0", oe_seen); end
    checks++;
    if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL m86_evcount got=%0d exp=%0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      $display("m86 ev%0d kind=%0d a=%0d b=%0d", i, obs_q[i].kind, obs_q[i].a, obs_q[i].b);
      if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL m86_ev%0d got=%h exp=%h", i, obs_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_slave_8080();
    logic [2:0] cl, ch;
    start_seq();
    sngl = 1'b0; sp_en = 1'b0; mode_8086 = 1'b0; slave_id = 3'd2; cas_in = 3'd2; int_pending = 1'b1; int_id = 3'd3;
    exp_q.push_back(mk(0, 3, 0)); exp_q.push_back(mk(1, 1, 0)); exp_q.push_back(mk(1, 2, 1));
    exp_q.push_back(mk(1, 3, 1)); exp_q.push_back(mk(2, 0, 0));
    for (int p = 0; p < 3; p++) begin
      pulse(6, 8, cl, ch);
      checks++; if (cl !== 3'd0) begin errors++; $display("FAIL s80_cas_p%0d got=%0d exp=0", p + 1, cl); end
    end
    repeat (4) @(posedge clk); #1;
    checks++; if (cas_oe !== 1'b0) begin errors++; $display("FAIL s80_cas_oe got=%b exp=0", cas_oe); end
    checks++;
    if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL s80_evcount got=%0d exp=%0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      $display("s80 ev%0d kind=%0d a=%0d b=%0d", i, obs_q[i].kind, obs_q[i].a, obs_q[i].b);
      if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL s80_ev%0d got=%h exp=%h", i, obs_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_single_8080();
    logic [2:0] cl, ch;
    start_seq();
    sngl = 1'b1; sp_en = 1'b0; mode_8086 = 1'b0; slave_mask = 8'hFF; int_pending = 1'b0; int_id = 3'd4;
    exp_q.push_back(mk(0, 7, 0)); exp_q.push_back(mk(1, 1, 1)); exp_q.push_back(mk(1, 2, 1));
    exp_q.push_back(mk(1, 3, 1)); exp_q.push_back(mk(2, 0, 0));
    for (int p = 0; p < 3; p++) begin
      pulse(6, 8, cl, ch);
      checks++; if (cl !== 3'd0) begin errors++; $display("FAIL sgl_cas_p%0d got=%0d exp=0", p + 1, cl); end
    end
    repeat (4) @(posedge clk); #1;
    checks++; if (ack_id !== 3'd7) begin errors++; $display("FAIL sgl_ack_id got=%0d exp=7", ack_id); end
    checks++;
    if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL sgl_evcount got=%0d exp=%0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      $display("sgl ev%0d kind=%0d a=%0d b=%0d", i, obs_q[i].kind, obs_q[i].a, obs_q[i].b);
      if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL sgl_ev%0d got=%h exp=%h", i, obs_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_gap_timeout();
    logic [2:0] cl, ch;
    start_seq();
    sngl = 1'b0; sp_en = 1'b1; mode_8086 = 1'b1; slave_mask = 8'h04; int_pending = 1'b1; int_id = 3'd2;
    exp_q.push_back(mk(0, 2, 0)); exp_q.push_back(mk(3, 0, 0));
    pulse(6, 100, cl, ch);
    checks++; if (ch !== 3'd0) begin errors++; $display("FAIL gap_cas_after_abort got=%0d exp=0", ch); end
    // Fresh sequence on an IR with no slave: byte must come on the second pulse.
    int_id = 3'd5;
    exp_q.push_back(mk(0, 5, 0)); exp_q.push_back(mk(1, 2, 1)); exp_q.push_back(mk(2, 0, 0));
    pulse(6, 8, cl, ch);
    pulse(6, 8, cl, ch);
    repeat (4) @(posedge clk); #1;
    checks++;
    if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL gap_evcount got=%0d exp=%0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      $display("gap ev%0d kind=%0d a=%0d b=%0d", i, obs_q[i].kind, obs_q[i].a, obs_q[i].b);
      if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL gap_ev%0d got=%h exp=%h", i, obs_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_reset_mid();
    logic [2:0] cl, ch;
    start_seq();
    sngl = 1'b0; sp_en = 1'b1; mode_8086 = 1'b0; slave_mask = 8'h00; int_pending = 1'b1; int_id = 3'd1;
    exp_q.push_back(mk(0, 1, 0)); exp_q.push_back(mk(1, 1, 1)); exp_q.push_back(mk(1, 2, 1));
    pulse(6, 8, cl, ch);
    @(posedge clk); #1 inta_n = 1'b0;
    repeat (5) @(posedge clk); #1;
    checks++; if ({vec_sel, data_oe} !== 3'b101) begin errors++; $display("FAIL rst_pre_byte got=%b exp=101", {vec_sel, data_oe}); end
    rst_n = 1'b0; #1;
    checks++;
    if ({vec_sel, data_oe, ack_start, seq_done, cas_out} !== 8'd0) begin
      errors++; $display("FAIL rst_async_clear got=%h exp=00", {vec_sel, data_oe, ack_start, seq_done, cas_out});
    end
    inta_n = 1'b1;
    repeat (3) @(posedge clk); #1 rst_n = 1'b1;
    repeat (2) @(posedge clk); #1;
    checks++;
    if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL rst_pre_evcount got=%0d exp=%0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      $display("rst-pre ev%0d kind=%0d a=%0d b=%0d", i, obs_q[i].kind, obs_q[i].a, obs_q[i].b);
      if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL rst_pre_ev%0d got=%h exp=%h", i, obs_q[i], exp_q[i]); end
    end
    start_seq();
    exp_q.push_back(mk(0, 1, 0)); exp_q.push_back(mk(1, 1, 1)); exp_q.push_back(mk(1, 2, 1));
    exp_q.push_back(mk(1, 3, 1)); exp_q.push_back(mk(2, 0, 0));
    for (int p = 0; p < 3; p++) pulse(6, 8, cl, ch);
    repeat (4) @(posedge clk); #1;
    checks++;
    if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL rst_post_evcount got=%0d exp=%0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      $display("rst-post ev%0d kind=%0d a=%0d b=%0d", i, obs_q[i].kind, obs_q[i].a, obs_q[i].b);
      if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL rst_post_ev%0d got=%h exp=%h", i, obs_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_slave_mismatch();
    logic [2:0] cl, ch;
    start_seq();
    sngl = 1'b0; sp_en = 1'b0; mode_8086 = 1'b0; slave_id = 3'd2; cas_in = 3'd5; int_pending = 1'b1; int_id = 3'd6;
    exp_q.push_back(mk(0, 6, 0)); exp_q.push_back(mk(1, 1, 0)); exp_q.push_back(mk(1, 2, 0));
    exp_q.push_back(mk(1, 3, 0));
    for (int p = 0; p < 3; p++) pulse(6, 8, cl, ch);
    repeat (4) @(posedge clk); #1;
    checks++; if (oe_seen !== 1'b0) begin errors++; $display("FAIL smis_data_oe got=%b exp=0", oe_seen); end
    checks++;
    if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL smis_evcount got=%0d exp=%0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      $display("smis ev%0d kind=%0d a=%0d b=%0d", i, obs_q[i].kind, obs_q[i].a, obs_q[i].b);
      if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL smis_ev%0d got=%h exp=%h", i, obs_q[i], exp_q[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_master_8086();
    test_slave_8080();
    test_single_8080();
    test_gap_timeout();
    test_reset_mid();
    test_slave_mismatch();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
